// File: rtl/comparator_2bit.sv
// comparator_2bit: registered unsigned magnitude comparator with
// per-result saturating event counters.
//
// Valid semantics: in_valid qualifies A/B on the sampling clk edge; there is
// no ready, so every cycle with in_valid=1 is accepted. out_valid is high for
// exactly the one cycle after each accepted compare. The flags keep their
// last result while out_valid is low. Every output comes from a register.
module comparator_2bit #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic             out_valid,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;

  logic             gt_q,  gt_d;
  logic             lt_q,  lt_d;
  logic             eq_q,  eq_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;

  // Unsigned magnitude compare of the raw operands; exactly one term is true.
  always_comb begin
    cmp_gt = (A > B);
    cmp_lt = (A < B);
    cmp_eq = (A == B);
  end

  // Next state for the result flags: load on accept, otherwise hold.
  always_comb begin
    gt_d  = gt_q;
    lt_d  = lt_q;
    eq_d  = eq_q;
    vld_d = in_valid;
    if (in_valid) begin
      gt_d = cmp_gt;
      lt_d = cmp_lt;
      eq_d = cmp_eq;
    end
  end

  // Next state for the counters: clear beats increment; only the matching one moves.
  always_comb begin
    gt_cnt_d = gt_cnt_q;
    lt_cnt_d = lt_cnt_q;
    eq_cnt_d = eq_cnt_q;
    if (cnt_clr) begin
      gt_cnt_d = '0;
      lt_cnt_d = '0;
      eq_cnt_d = '0;
    end else if (in_valid) begin
      if (cmp_gt) gt_cnt_d = sat_inc(gt_cnt_q);
      if (cmp_lt) lt_cnt_d = sat_inc(lt_cnt_q);
      if (cmp_eq) eq_cnt_d = sat_inc(eq_cnt_q);
    end
  end

  // State registers; reset clears everything immediately, dropping any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      vld_q    <= 1'b0;
      gt_cnt_q <= '0;
      lt_cnt_q <= '0;
      eq_cnt_q <= '0;
    end else begin
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      vld_q    <= vld_d;
      gt_cnt_q <= gt_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      eq_cnt_q <= eq_cnt_d;
    end
  end

  assign A_gt_B    = gt_q;
  assign A_lt_B    = lt_q;
  assign A_eq_B    = eq_q;
  assign out_valid = vld_q;
  assign gt_cnt    = gt_cnt_q;
  assign lt_cnt    = lt_cnt_q;
  assign eq_cnt    = eq_cnt_q;

endmodule

// File: tb/tb_comparator_2bit.sv
// tb_comparator_2bit: directed bench for comparator_2bit. A second instance
// with 2-bit counters shares all inputs and is used for saturation.
module tb_comparator_2bit;

  logic       clk;
  logic       rst;
  logic [1:0] a;
  logic [1:0] b;
  logic       in_valid;
  logic       cnt_clr;

  logic       gt, lt, eq, ov;
  logic [7:0] gt_cnt, lt_cnt, eq_cnt;
  logic       s_gt, s_lt, s_eq, s_ov;
  logic [1:0] s_gt_cnt, s_lt_cnt, s_eq_cnt;

  int n_cmp;
  int n_bad;

  comparator_2bit #(.WIDTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .A_gt_B(gt), .A_lt_B(lt), .A_eq_B(eq), .out_valid(ov),
    .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt)
  );

  comparator_2bit #(.WIDTH(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .A(a), .B(b), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .A_gt_B(s_gt), .A_lt_B(s_lt), .A_eq_B(s_eq), .out_valid(s_ov),
    .gt_cnt(s_gt_cnt), .lt_cnt(s_lt_cnt), .eq_cnt(s_eq_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // onehot invariant whenever a fresh result is presented
  always @(negedge clk) begin
    if (!rst && ov) begin
      n_cmp++;
      if ({1'b0, gt} + {1'b0, lt} + {1'b0, eq} !== 2'd1) begin
        n_bad++;
        $display("FAIL onehot: got gt=%b lt=%b eq=%b, want exactly one set", gt, lt, eq);
      end
    end
  end

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 2'd3; b = 2'd0; in_valid = 1'b1; cnt_clr = 1'b0;
    #1;
    n_cmp++;
    if ({gt, lt, eq, ov} !== 4'b0000 || {gt_cnt, lt_cnt, eq_cnt} !== 24'd0) begin
      n_bad++;
      $display("FAIL reset_async: got flags=%b%b%b%b cnt=%0d/%0d/%0d, want all 0",
               gt, lt, eq, ov, gt_cnt, lt_cnt, eq_cnt);
    end
    step(); step();
    n_cmp++;
    if ({gt, lt, eq, ov} !== 4'b0000 || {gt_cnt, lt_cnt, eq_cnt} !== 24'd0) begin
      n_bad++;
      $display("FAIL reset_held: got flags=%b%b%b%b cnt=%0d/%0d/%0d, want all 0",
               gt, lt, eq, ov, gt_cnt, lt_cnt, eq_cnt);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    int eg, el, ee;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a = 2'(i); b = 2'(j); in_valid = 1'b1;
        step();
        eg = (i > j) ? 1 : 0;
        el = (i < j) ? 1 : 0;
        ee = (i == j) ? 1 : 0;
        n_cmp++;
        if ({gt, lt, eq, ov} !== {1'(eg), 1'(el), 1'(ee), 1'b1}) begin
          n_bad++;
          $display("FAIL sweep A=%0d B=%0d: got gt=%b lt=%b eq=%b ov=%b, want %0d %0d %0d 1",
                   i, j, gt, lt, eq, ov, eg, el, ee);
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (gt_cnt !== 8'd6 || lt_cnt !== 8'd6 || eq_cnt !== 8'd4) begin
      n_bad++;
      $display("FAIL sweep_counts: got %0d/%0d/%0d, want 6/6/4", gt_cnt, lt_cnt, eq_cnt);
    end
    step();
  endtask

  task automatic test_hold();
    a = 2'd3; b = 2'd0; in_valid = 1'b1;
    step();
    n_cmp++;
    if ({gt, lt, eq, ov} !== 4'b1001) begin
      n_bad++;
      $display("FAIL hold_load: got %b%b%b%b, want 1001", gt, lt, eq, ov);
    end
    a = 2'd0; b = 2'd3; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({gt, lt, eq, ov} !== 4'b1000) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got %b%b%b%b, want 1000", k, gt, lt, eq, ov);
      end
    end
    n_cmp++;
    if (gt_cnt !== 8'd7 || lt_cnt !== 8'd6 || eq_cnt !== 8'd4) begin
      n_bad++;
      $display("FAIL hold_counts: got %0d/%0d/%0d, want 7/6/4", gt_cnt, lt_cnt, eq_cnt);
    end
  endtask

  task automatic test_async_reset();
    a = 2'd0; b = 2'd2; in_valid = 1'b1;
    step();
    n_cmp++;
    if ({gt, lt, eq, ov} !== 4'b0101) begin
      n_bad++;
      $display("FAIL arst_pre: got %b%b%b%b, want 0101", gt, lt, eq, ov);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({gt, lt, eq, ov} !== 4'b0000 || {gt_cnt, lt_cnt, eq_cnt} !== 24'd0) begin
      n_bad++;
      $display("FAIL arst_now: got flags=%b%b%b%b cnt=%0d/%0d/%0d, want all 0",
               gt, lt, eq, ov, gt_cnt, lt_cnt, eq_cnt);
    end
    // request presented while in reset must not appear
    a = 2'd3; b = 2'd1;
    step();
    n_cmp++;
    if ({gt, lt, eq, ov} !== 4'b0000 || gt_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL arst_discard: got %b%b%b%b gt_cnt=%0d, want 0000 0", gt, lt, eq, ov, gt_cnt);
    end
    a = 2'd2; b = 2'd2;
    rst = 1'b0;
    step();
    n_cmp++;
    if ({gt, lt, eq, ov} !== 4'b0011 || eq_cnt !== 8'd1 || gt_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL arst_first_edge: got %b%b%b%b eq_cnt=%0d gt_cnt=%0d, want 0011 1 0",
               gt, lt, eq, ov, eq_cnt, gt_cnt);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1; in_valid = 1'b0;
    step();
    cnt_clr = 1'b0;
    a = 2'd0; b = 2'd0; in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++;
      if (s_eq_cnt !== ((k < 3) ? 2'(k) : 2'd3)) begin
        n_bad++;
        $display("FAIL sat_step%0d: got eq_cnt=%0d, want %0d", k, s_eq_cnt, (k < 3) ? k : 3);
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (s_eq_cnt !== 2'd3 || s_gt_cnt !== 2'd0 || s_lt_cnt !== 2'd0 || eq_cnt !== 8'd5) begin
      n_bad++;
      $display("FAIL sat_final: got sat %0d/%0d/%0d wide eq=%0d, want 0/0/3 wide 5",
               s_gt_cnt, s_lt_cnt, s_eq_cnt, eq_cnt);
    end
    step();
  endtask

  task automatic test_clear_priority();
    a = 2'd1; b = 2'd0; in_valid = 1'b1; cnt_clr = 1'b1;
    step();
    n_cmp++;
    if (gt_cnt !== 8'd0 || eq_cnt !== 8'd0 || {gt, lt, eq, ov} !== 4'b1001) begin
      n_bad++;
      $display("FAIL clr_prio: got gt_cnt=%0d eq_cnt=%0d flags=%b%b%b%b, want 0 0 1001",
               gt_cnt, eq_cnt, gt, lt, eq, ov);
    end
    cnt_clr = 1'b0;
    step();
    n_cmp++;
    if (gt_cnt !== 8'd1 || lt_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL clr_after: got gt_cnt=%0d lt_cnt=%0d, want 1 0", gt_cnt, lt_cnt);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] va [6];
    logic [1:0] vb [6];
    logic [2:0] ve [6];
    va = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd3, 2'd2};
    vb = '{2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd3};
    ve = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b010};
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = va[k]; b = vb[k];
      step();
      n_cmp++;
      if ({gt, lt, eq, ov} !== {ve[k], 1'b1}) begin
        n_bad++;
        $display("FAIL b2b_%0d: got %b%b%b%b, want %b1", k, gt, lt, eq, ov, ve[k]);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (gt_cnt !== 8'd2 || lt_cnt !== 8'd3 || eq_cnt !== 8'd1 || ov !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_counts: got %0d/%0d/%0d ov=%b, want 2/3/1 0", gt_cnt, lt_cnt, eq_cnt, ov);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_sweep();
    test_hold();
    test_async_reset();
    test_saturation();
    test_clear_priority();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/comparator_2bit.md
COMPARATOR_2BIT -- requirements
Module: comparator_2bit

Interface
REQ-001 Parameter WIDTH, default 2, operand width in bits; the SHALL values below are stated for WIDTH=2, and the design SHALL be correct for any WIDTH>=1.
REQ-002 Parameter CNT_W, default 8, width of each saturating result counter.
REQ-003 One clock; reset is asynchronous and active-high: clk input 1, rising-edge clock for all state.
REQ-004 rst input 1, asynchronous active-high reset.
REQ-005 A input WIDTH, unsigned operand A.
REQ-006 B input WIDTH, unsigned operand B.
REQ-007 in_valid input 1, high when A/B hold a compare request; sampled on the clk rising edge.
REQ-008 cnt_clr input 1, synchronous clear of all result counters.
REQ-009 A_gt_B output 1, registered flag for A>B.
REQ-010 A_lt_B output 1, registered flag for A<B.
REQ-011 A_eq_B output 1, registered flag for A==B.
REQ-012 out_valid output 1, high when the three flags hold a fresh result.
REQ-013 gt_cnt output CNT_W, number of accepted compares with A>B.
REQ-014 lt_cnt output CNT_W, number of accepted compares with A<B.
REQ-015 eq_cnt output CNT_W, number of accepted compares with A==B.

Function
REQ-016 Comparison SHALL be unsigned magnitude over all WIDTH bits.
- For WIDTH=2: 0<1<2<3.
- There SHALL be no sign interpretation.
REQ-017 On a rising edge with in_valid=1, the flags SHALL load the result of the sampled A,B.
- Latency is 1 cycle.
- out_valid SHALL be 1 in the following cycle.
REQ-018 On a rising edge with in_valid=0:
- out_valid SHALL go to 0.
- The flags SHALL hold their previous values.
REQ-019 After any accepted compare, exactly one of A_gt_B, A_lt_B, A_eq_B SHALL be 1.
REQ-020 Back-to-back in_valid=1 SHALL give one result per cycle, with no stall.
REQ-021 On each accepted compare, the counter matching the result SHALL increment by 1.
- The counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
- The other two counters SHALL be unchanged.
REQ-022 cnt_clr=1 on a rising edge SHALL zero all three counters.
- cnt_clr SHALL take priority over a simultaneous increment.
- The flags and out_valid SHALL still update per REQ-017/018.
REQ-023 Inputs SHALL have no combinational path to any output.

Reset
REQ-024 While rst=1, independent of clk:
- A_gt_B=0, A_lt_B=0, A_eq_B=0.
- out_valid=0.
- gt_cnt=0, lt_cnt=0, eq_cnt=0.
REQ-025 Reset asserted mid-stream SHALL discard any in-flight result.
REQ-026 The first rising edge after rst deasserts SHALL operate normally; inputs are sampled on that edge.

Verification
REQ-027 Exhaustive sweep: all 16 (A,B) pairs, A outer loop 0..3, B inner 0..3, in_valid=1, one pair per cycle.
- Each result appears 1 cycle later.
- Example: A=2,B=1 -> gt=1,lt=0,eq=0.
- Example: A=1,B=3 -> 0,1,0.
- Example: A=3,B=3 -> 0,0,1.
- After the sweep: gt_cnt=6, lt_cnt=6, eq_cnt=4.
REQ-028 Hold case: A=3,B=0 accepted, then in_valid=0 for 3 cycles.
- Flags SHALL stay gt=1.
- out_valid SHALL be 1 for one cycle only.
REQ-029 Async reset: assert rst mid-cycle after A=0,B=2.
- All outputs SHALL go to 0 immediately, with no clock edge.
REQ-030 Saturation with CNT_W=2: 5 accepted A=0,B=0 compares.
- eq_cnt SHALL be 3.
- gt_cnt and lt_cnt SHALL be 0.
REQ-031 Clear priority: cnt_clr=1 together with an accepted A=1,B=0.
- Next cycle gt_cnt=0 and A_gt_B=1.
REQ-032 Throughout all scenarios, the onehot invariant of REQ-019 SHALL hold whenever out_valid=1.
